// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO with a valid/ready push port.
// Frames are serialised LSB first; queued bytes follow each other with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [CW-1:0]              CNT_INC  = CW'(1);
  localparam logic [CW-1:0]              CNT_FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic [1:0]                 state;
  logic [CNT_W-1:0]           baud_cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shift;
  logic                       txd_q;
  logic                       push;
  logic                       pop;
  logic                       have_data;
  logic                       baud_last;

  assign have_data  = (count != '0);
  assign baud_last  = (baud_cnt == CNT_LAST);
  assign tx_ready   = !rst && (count != CNT_FULL);
  assign push       = tx_valid && tx_ready;
  // The only pops are FSM loads: from IDLE, or chained at the end of a stop bit.
  assign pop        = have_data && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
  assign fifo_count = count;
  assign txd        = txd_q;
  assign busy       = (state != S_IDLE) || have_data;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_INC;
        2'b01:   count <= count - CNT_INC;
        default: ;
      endcase
    end
  end

  // Shift register holds payload only; txd always presents shift[0] of the current bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if ((state == S_DATA) && baud_last) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          txd_q    <= 1'b1;
          baud_cnt <= '0;
          if (have_data) begin
            txd_q <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_q    <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= S_STOP;
            end else begin
              txd_q   <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (have_data) begin
              txd_q <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
